if_id_fetch_queue: RTL and testbench
====================================

// Module: if_id_fetch_queue
// PURPOSE
//  Consumer end of the instruction-fetch interface: accepts {instruction, PC, PC+4} from fetch,
//  buffers them in a small FIFO and presents them to decode with valid/ready. Drives PCWrite back
//  to fetch as back-pressure: fetch holds its PC while PCWrite=0. Flushes wrong-path entries on a
//  taken branch (or_out | Branchreg) so the redirected PC loads cleanly. Sits in place of the IF/ID register.
// PARAMETERS
//  DEPTH       4           entries; power of two, >=2
//  INSTR_W     32          instruction width
//  ADDR_W      64          PC width
// PORTS
//  clock               in   1        single clock, rising edge
//  reset               in   1        asynchronous, active-low
//  instruction_in      in   INSTR_W  fetched instruction (fetch instruction_out)
//  PC_in               in   ADDR_W   PC of instruction_in (fetch PC_out)
//  PC_link_in          in   ADDR_W   PC+4 (fetch PC_branch_link_out)
//  flush               in   1        taken branch/redirect resolved this cycle
//  PCWrite             out  1        1 = current fetch word accepted at this edge, PC may advance
//  id_ready            in   1        decode can consume head this cycle (0 = hazard stall)
//  id_valid            out  1        head entry valid
//  instruction_out     out  INSTR_W  head instruction; NOP when id_valid=0
//  PC_out              out  ADDR_W   head PC; 0 when id_valid=0
//  PC_link_out         out  ADDR_W   head PC+4; 0 when id_valid=0
//  count               out  log2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset (reset=0, async): count=0, rd/wr pointers=0, id_valid=0, instruction_out=NOP, PC_out=0,
//    PC_link_out=0; PCWrite=1 as soon as reset is released. Storage contents need no reset.
//  - PCWrite = flush | (count != DEPTH). Combinational from count and flush only; never from id_ready.
//  - push = PCWrite & ~flush: writes {instruction_in, PC_in, PC_link_in} at wr_ptr, wr_ptr++ (mod DEPTH).
//  - pop = id_valid & id_ready & ~flush: rd_ptr++ (mod DEPTH).
//  - count' = count + push - pop; push & pop in the same cycle leaves count unchanged.
//  - Outputs read combinationally from the rd_ptr entry; id_valid = (count != 0).
//  - Latency: a word pushed into an empty queue at edge n appears on id_* after edge n (1 cycle).
//  - Full (count==DEPTH): PCWrite=0, no push; a pop that cycle frees a slot, PCWrite=1 next cycle.
//  - Empty: id_valid=0, outputs forced to NOP/0; id_ready is ignored.
//  - Flush has priority over push and pop: at the edge count=0, rd_ptr=wr_ptr=0, the fetch word
//    presented that cycle is dropped, and PCWrite=1 so fetch loads the branch target.
//  - Pointer wrap: pointers are log2(DEPTH) bits; wrap is natural overflow.
//  - Reset asserted mid-operation: immediate clear regardless of flush/push/pop.
//  - No assertion-free overflow/underflow: push while full or pop while empty is impossible by construction.
// STRUCTURE
//  - Shared package armv8_pkg: INSTR_W, ADDR_W, NOP encoding 32'hD503201F, fetch-entry struct
//    {instr, pc, pc_link}.
//  - One sub-module: fetch_queue_mem (DEPTH x entry register array, 1 write port, 1 async read
//    port, no reset). Pointers, count and control stay in if_id_fetch_queue.
// TESTING
//  1. Reset release, id_ready=1, fetch PC 0,4,8 -> PCWrite=1 every cycle; id_valid rises 1 cycle
//     after first push; PC_out 0,4,8 in consecutive cycles; PC_link_out=PC_out+4.
//  2. id_ready=0 with DEPTH=4 -> count 1,2,3,4; PCWrite=0 in the cycle count=4; then id_ready=1
//     for 1 cycle -> count 3, PCWrite=1 next cycle, order preserved (PC 0 first).
//  3. count=3, push & pop same cycle -> count stays 3; head advances to next PC.
//  4. count=4 (full), flush=1 -> PCWrite=1 that cycle; next cycle count=0, id_valid=0,
//     instruction_out=32'hD503201F; next fetched word (branch target 0x100) appears alone.
//  5. Wrap: 10 push/pop cycles with DEPTH=4 -> PC_out sequence contiguous across pointer wrap.
//  6. reset=0 asynchronously while count=2 -> id_valid=0, count=0, PC_out=0 before next clock edge.

Source files
------------

// File: rtl/armv8_pkg.sv
// Shared front-end types: datapath widths, the NOP encoding and the fetch-entry payload.
package armv8_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;

  localparam logic [INSTR_W-1:0] NOP = 32'hD503201F;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_link;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch-queue storage: DEPTH entries, one synchronous write port, one asynchronous read port.
module fetch_queue_mem
  import armv8_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  fetch_entry_t               wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output fetch_entry_t               rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  // Contents are qualified by the queue's occupancy, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: buffers fetched words for decode, back-pressures fetch via PCWrite,
// and drops wrong-path entries on a redirect.
module if_id_fetch_queue
  import armv8_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [INSTR_W-1:0]       instruction_in,
  input  logic [ADDR_W-1:0]        PC_in,
  input  logic [ADDR_W-1:0]        PC_link_in,
  input  logic                     flush,
  output logic                     PCWrite,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [INSTR_W-1:0]       instruction_out,
  output logic [ADDR_W-1:0]        PC_out,
  output logic [ADDR_W-1:0]        PC_link_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  fetch_entry_t     wr_entry, head_entry;

  // Back-pressure and handshakes depend only on occupancy and flush, never on id_ready for PCWrite.
  assign PCWrite  = flush | (count_q != FULL_CNT);
  assign id_valid = (count_q != '0);
  assign push     = PCWrite & ~flush;
  assign pop      = id_valid & id_ready & ~flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_entry = '{instr: instruction_in, pc: PC_in, pc_link: PC_link_in};

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clock),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  // An empty queue presents a bubble so decode never sees stale storage.
  assign instruction_out = id_valid ? head_entry.instr   : NOP;
  assign PC_out          = id_valid ? head_entry.pc      : '0;
  assign PC_link_out     = id_valid ? head_entry.pc_link : '0;
  assign count           = count_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for if_id_fetch_queue: queue-based reference model, directed scenarios, random traffic.
module tb_if_id_fetch_queue;
  import armv8_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic               clock;
  logic               reset;
  logic [INSTR_W-1:0] instruction_in;
  logic [ADDR_W-1:0]  PC_in;
  logic [ADDR_W-1:0]  PC_link_in;
  logic               flush;
  logic               PCWrite;
  logic               id_ready;
  logic               id_valid;
  logic [INSTR_W-1:0] instruction_out;
  logic [ADDR_W-1:0]  PC_out;
  logic [ADDR_W-1:0]  PC_link_out;
  logic [2:0]         count;

  if_id_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .instruction_in  (instruction_in),
    .PC_in           (PC_in),
    .PC_link_in      (PC_link_in),
    .flush           (flush),
    .PCWrite         (PCWrite),
    .id_ready        (id_ready),
    .id_valid        (id_valid),
    .instruction_out (instruction_out),
    .PC_out          (PC_out),
    .PC_link_out     (PC_link_out),
    .count           (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  fetch_entry_t    mq[$];
  logic [63:0]     fetch_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle against the queue model.
  always @(negedge clock) begin
    chk("pcwrite", 64'(PCWrite), 64'(flush | (mq.size() != DEPTH)));
    chk("count",   64'(count),   64'(mq.size()));
    chk("id_valid", 64'(id_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("instr",   64'(instruction_out), 64'(mq[0].instr));
      chk("pc",      PC_out,      mq[0].pc);
      chk("pc_link", PC_link_out, mq[0].pc_link);
    end else begin
      chk("instr_nop", 64'(instruction_out), 64'(NOP));
      chk("pc_zero",   PC_out,      64'd0);
      chk("link_zero", PC_link_out, 64'd0);
    end
  end

  task automatic drive(input bit fl, input bit rdy);
    flush          = fl;
    id_ready       = rdy;
    instruction_in = $urandom;
    PC_in          = fetch_pc;
    PC_link_in     = fetch_pc + 64'd4;
  endtask

  // Advance one clock; model the queue and the fetch PC from the inputs held across the edge.
  task automatic tick(input logic [63:0] target);
    bit pcw, do_push, do_pop;
    fetch_entry_t e;
    @(posedge clock);
    if (!reset) begin
      mq.delete();
    end else begin
      pcw = flush || (mq.size() != DEPTH);
      if (flush) begin
        mq.delete();
      end else begin
        do_push = (mq.size() != DEPTH);
        do_pop  = (mq.size() != 0) && id_ready;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          e.instr = instruction_in; e.pc = PC_in; e.pc_link = PC_link_in;
          mq.push_back(e);
        end
      end
      if (pcw) fetch_pc = flush ? target : fetch_pc + 64'd4;
    end
    @(negedge clock);
    #1;
  endtask

  task automatic step(input bit fl, input bit rdy, input logic [63:0] target);
    drive(fl, rdy);
    tick(target);
  endtask

  initial begin
    reset = 1'b0;
    fetch_pc = 64'd0;
    drive(1'b0, 1'b1);
    repeat (2) @(negedge clock);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_instr", 64'(instruction_out), 64'hD503201F);
    chk("rst_pc", PC_out, 64'd0);
    reset = 1'b1;
    chk("rel_pcwrite", 64'(PCWrite), 64'd1);

    // 1: streaming with decode ready
    step(1'b0, 1'b1, 64'd0);
    chk("t1_valid", 64'(id_valid), 64'd1);
    chk("t1_pc0", PC_out, 64'd0);
    chk("t1_link0", PC_link_out, 64'd4);
    step(1'b0, 1'b1, 64'd0);
    chk("t1_pc4", PC_out, 64'd4);
    step(1'b0, 1'b1, 64'd0);
    chk("t1_pc8", PC_out, 64'd8);
    chk("t1_link8", PC_link_out, 64'd12);

    // 2: fill under stall, then drain one
    step(1'b1, 1'b1, 64'd0);
    chk("t2_flushed", 64'(count), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 64'd0);
      chk("t2_count", 64'(count), 64'(i));
    end
    chk("t2_full_pcw", 64'(PCWrite), 64'd0);
    chk("t2_head", PC_out, 64'd0);
    step(1'b0, 1'b1, 64'd0);
    chk("t2_count3", 64'(count), 64'd3);
    chk("t2_pcw", 64'(PCWrite), 64'd1);
    chk("t2_head4", PC_out, 64'd4);

    // 3: simultaneous push and pop at count 3
    step(1'b0, 1'b1, 64'd0);
    chk("t3_count", 64'(count), 64'd3);
    chk("t3_head", PC_out, 64'd8);

    // 4: flush while full
    step(1'b0, 1'b0, 64'd0);
    chk("t4_full", 64'(count), 64'd4);
    drive(1'b1, 1'b0);
    #1;
    chk("t4_pcw_flush", 64'(PCWrite), 64'd1);
    tick(64'h100);
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_valid", 64'(id_valid), 64'd0);
    chk("t4_nop", 64'(instruction_out), 64'hD503201F);
    step(1'b0, 1'b0, 64'd0);
    chk("t4_target", PC_out, 64'h100);
    chk("t4_alone", 64'(count), 64'd1);

    // 5: pointer wrap with steady push/pop
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 64'd0);
      chk("t5_wrap_pc", PC_out, 64'h104 + 64'(4 * i));
    end

    // 6: asynchronous reset at count 2
    step(1'b0, 1'b0, 64'd0);
    chk("t6_count2", 64'(count), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_valid", 64'(id_valid), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_pc", PC_out, 64'd0);
    mq.delete();
    tick(64'd0);
    reset = 1'b1;
    fetch_pc = 64'h2000;

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
           64'({$urandom_range(0, 255), 2'b00}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
